// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
package fetch_pkg;

    localparam int          XLEN      = 32;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic {
        REQ  = 1'b0,
        WAIT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
        logic            misaligned;
    } fetch_entry_t;

    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] pc);
        return {pc[XLEN-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_buffer.sv
// Small synchronous FIFO of fetch entries between the memory port and decode.
module fetch_buffer
    import fetch_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic             clear_i,
    input  fetch_entry_t     wdata_i,
    output fetch_entry_t     rdata_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop_i)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is deliberately not reset; the empty flag gates everything read from it.
    always_ff @(posedge clk) begin
        if (push_i && !clear_i) mem_q[wr_ptr_q] <= wdata_i;
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;

`ifndef SYNTHESIS
    a_no_push_full:  assert property (@(posedge clk) disable iff (!rst_n) !(push_i && full_o));
    a_no_pop_empty:  assert property (@(posedge clk) disable iff (!rst_n) !(pop_i && empty_o));
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: one memory request per PC value, responses buffered with their PC for decode.
module instr_fetch_unit
    import fetch_pkg::*;
#(
    parameter int BUF_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] pc_current,
    input  logic            flush,
    output logic            pc_stall,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [31:0]     imem_rsp_data,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic            if_misaligned
);

    localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

    fetch_state_e    state_q, state_d;
    logic            drop_q, drop_d;
    logic [XLEN-1:0] req_pc_q, req_pc_d;
    logic            req_mis_q, req_mis_d;

    logic [CNT_W-1:0] count;
    logic             full, empty, space, outstanding;
    logic             req_fire, push, pop;
    fetch_entry_t     head, wr_entry;

    // A single request can be in flight, so WAIT doubles as the outstanding count.
    assign outstanding    = (state_q == WAIT);
    assign space          = (count + CNT_W'(outstanding)) < CNT_W'(BUF_DEPTH);
    assign imem_req_valid = (state_q == REQ) && !flush && space;
    assign imem_req_addr  = align_word(pc_current);
    assign req_fire       = imem_req_valid && imem_req_ready;
    assign pc_stall       = !req_fire && !flush;

    assign push = outstanding && imem_rsp_valid && !drop_q && !flush;
    assign pop  = if_valid && if_ready && !flush;

    assign wr_entry = '{pc:         req_pc_q,
                        instr:      req_mis_q ? NOP_INSTR : imem_rsp_data,
                        misaligned: req_mis_q};

    // NOTE: every next-state signal gets a default first so no path infers a latch.
    always_comb begin
        state_d   = state_q;
        drop_d    = drop_q;
        req_pc_d  = req_pc_q;
        req_mis_d = req_mis_q;
        case (state_q)
            REQ: begin
                if (req_fire) begin
                    req_pc_d  = pc_current;
                    req_mis_d = (pc_current[1:0] != 2'b00);
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                // A response landing with a flush is wrong-path work and is dropped via !flush in push.
                if (imem_rsp_valid) begin
                    drop_d  = 1'b0;
                    state_d = REQ;
                end else if (flush) begin
                    drop_d = 1'b1;
                end
            end
            default: state_d = REQ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= REQ;
            drop_q    <= 1'b0;
            req_pc_q  <= '0;
            req_mis_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            drop_q    <= drop_d;
            req_pc_q  <= req_pc_d;
            req_mis_q <= req_mis_d;
        end
    end

    fetch_buffer #(.DEPTH(BUF_DEPTH)) u_buf (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .clear_i (flush),
        .wdata_i (wr_entry),
        .rdata_o (head),
        .full_o  (full),
        .empty_o (empty),
        .count_o (count)
    );

    assign if_valid      = !empty;
    assign if_pc         = empty ? '0 : head.pc;
    assign if_instr      = empty ? '0 : head.instr;
    assign if_misaligned = !empty && head.misaligned;

`ifndef SYNTHESIS
    a_one_outstanding: assert property (@(posedge clk) disable iff (!rst_n) !(outstanding && imem_req_valid));
    a_no_req_full:     assert property (@(posedge clk) disable iff (!rst_n) !(imem_req_valid && full));
`endif

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench: PC and memory environment models plus a per-cycle fetch scoreboard.
module tb_instr_fetch_unit;

    localparam int          DEPTH = 2;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_current;
    logic        flush;
    logic        pc_stall;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_pc;
    logic [31:0] if_instr;
    logic        if_misaligned;

    always #5 clk = ~clk;

    instr_fetch_unit #(.BUF_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .pc_current     (pc_current),
        .flush          (flush),
        .pc_stall       (pc_stall),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .if_valid       (if_valid),
        .if_ready       (if_ready),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .if_misaligned  (if_misaligned)
    );

    typedef struct {
        logic [31:0] pc;
        int          due;
        bit          killed;
    } pend_t;

    pend_t       pend[$];     // requests accepted by memory, response not yet returned
    logic [31:0] scb[$];      // PCs of live fetches (outstanding or buffered), oldest first
    logic [31:0] seen[$];     // PCs handed to decode
    logic [31:0] seen_instr[$];
    logic        seen_mis[$];
    logic [31:0] pc;
    int          cyc;
    int          n_checks = 0;
    int          n_errors = 0;

    bit          k_flush, k_ready, k_if_ready, k_late_rsp;
    logic [31:0] k_target;
    int          k_lat;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000 ^ {a[15:0], 16'h0000};
    endfunction

    function automatic logic [31:0] exp_instr(input logic [31:0] p);
        return (p[1:0] != 2'b00) ? NOP : mem_word({p[31:2], 2'b00});
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_seen(input string tag, input int idx, input logic [31:0] exp);
        check(tag, (idx < seen.size()) ? seen[idx] : 32'hxxxx_xxxx, exp);
    endtask

    // One clock cycle: drive inputs, check outputs at negedge, advance models after posedge.
    task automatic tick();
        bit          exp_rv, fire, rsp, pop_e, stall_obs;
        int          live, buffered;
        flush          = k_flush;
        imem_req_ready = k_ready;
        if_ready       = k_if_ready;
        rsp            = (pend.size() > 0 && pend[0].due <= cyc) || k_late_rsp;
        imem_rsp_valid = rsp;
        imem_rsp_data  = (pend.size() > 0) ? mem_word({pend[0].pc[31:2], 2'b00}) : $urandom();
        pc_current     = pc;
        @(negedge clk);
        exp_rv = !k_flush && pend.size() == 0 && scb.size() < DEPTH;
        check("req_valid", imem_req_valid, exp_rv);
        fire = exp_rv && k_ready;
        check("pc_stall", pc_stall, !fire && !k_flush);
        if (exp_rv) check("req_addr", imem_req_addr, {pc[31:2], 2'b00});
        live = 0;
        foreach (pend[i]) if (!pend[i].killed) live++;
        buffered = scb.size() - live;
        check("if_valid", if_valid, buffered > 0);
        if (buffered > 0) begin
            check("if_pc", if_pc, scb[0]);
            check("if_instr", if_instr, exp_instr(scb[0]));
            check("if_misaligned", if_misaligned, scb[0][1:0] != 2'b00);
        end
        pop_e     = buffered > 0 && k_if_ready && !k_flush;
        stall_obs = pc_stall;
        if (pop_e) begin
            seen_instr.push_back(if_instr);
            seen_mis.push_back(if_misaligned);
        end
        @(posedge clk);
        #1;
        if (pop_e) seen.push_back(scb.pop_front());
        if (rsp && pend.size() > 0) void'(pend.pop_front());
        if (k_flush) begin
            scb.delete();
            foreach (pend[i]) pend[i].killed = 1'b1;
            pc = k_target;
        end else begin
            if (fire) begin
                pend.push_back('{pc, cyc + k_lat, 1'b0});
                scb.push_back(pc);
            end
            if (!stall_obs) pc = pc + 32'd4;
        end
        cyc++;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset();
        rst_n          = 1'b0;
        flush          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if_ready       = 1'b0;
        pc             = '0;
        pc_current     = '0;
        #2;
        check("rst_if_valid", if_valid, 1'b0);
        check("rst_if_pc", if_pc, 32'h0);
        check("rst_if_instr", if_instr, 32'h0);
        check("rst_if_mis", if_misaligned, 1'b0);
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        pend.delete();
        scb.delete();
        seen.delete();
        seen_instr.delete();
        seen_mis.delete();
        cyc        = 0;
        k_flush    = 1'b0;
        k_late_rsp = 1'b0;
        k_ready    = 1'b1;
        k_if_ready = 1'b1;
        k_lat      = 1;
        k_target   = '0;
    endtask

    initial begin
        int          base, found;
        logic [31:0] pc_hold;

        // Streaming fetch with single-cycle memory.
        do_reset();
        run(12);
        check_seen("seq_pc0", 0, 32'h0);
        check_seen("seq_pc1", 1, 32'h4);
        check_seen("seq_pc2", 2, 32'h8);
        check_seen("seq_pc3", 3, 32'hC);

        // Decode back-pressure fills the buffer and stops requests.
        do_reset();
        k_if_ready = 1'b0;
        run(10);
        check("bp_pc_hold", pc, 32'h8);
        check("bp_head_pc", if_pc, 32'h0);
        check("bp_no_req", imem_req_valid, 1'b0);
        k_if_ready = 1'b1;
        run(8);
        check_seen("bp_order0", 0, 32'h0);
        check_seen("bp_order1", 1, 32'h4);
        check_seen("bp_order2", 2, 32'h8);

        // Memory not ready: request held, PC frozen.
        run(4);
        pc_hold = pc;
        k_ready = 1'b0;
        run(3);
        check("nr_pc_frozen", pc, pc_hold);
        k_ready = 1'b1;
        run(6);

        // Flush while waiting on the 0x10 response.
        do_reset();
        k_lat = 3;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (pend.size() > 0 && pend[0].pc == 32'h10) found = 1;
            else tick();
        end
        check("reach_0x10", found, 1);
        base     = seen.size();
        k_flush  = 1'b1;
        k_target = 32'h100;
        tick();
        k_flush = 1'b0;
        check("flush_empty", if_valid, 1'b0);
        run(15);
        check_seen("flush_target", base, 32'h100);

        // Flush coincident with the response.
        k_lat = 1;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (pend.size() > 0 && pend[0].due == cyc) found = 1;
            else tick();
        end
        check("reach_rsp", found, 1);
        base     = seen.size();
        k_flush  = 1'b1;
        k_target = 32'h200;
        tick();
        k_flush = 1'b0;
        run(10);
        check_seen("coinc_target", base, 32'h200);

        // Redirect to a misaligned PC.
        base     = seen.size();
        k_flush  = 1'b1;
        k_target = 32'h102;
        tick();
        k_flush = 1'b0;
        run(10);
        check_seen("mis_pc", base, 32'h102);
        check("mis_instr", (base < seen_instr.size()) ? seen_instr[base] : 32'hxxxx_xxxx, NOP);
        check("mis_flag", (base < seen_mis.size()) ? seen_mis[base] : 1'bx, 1'b1);

        // Reset mid-request, then a stray late response.
        k_lat = 3;
        found = 0;
        for (int i = 0; i < 60 && !found; i++) begin
            if (pend.size() > 0) found = 1;
            else tick();
        end
        check("reach_wait", found, 1);
        do_reset();
        k_ready    = 1'b0;
        k_late_rsp = 1'b1;
        tick();
        k_late_rsp = 1'b0;
        run(2);
        check("late_rsp_ignored", if_valid, 1'b0);
        k_ready = 1'b1;
        run(6);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            k_ready    = ($urandom_range(0, 3) != 0);
            k_if_ready = ($urandom_range(0, 9) < 7);
            k_lat      = $urandom_range(1, 3);
            k_flush    = ($urandom_range(0, 31) == 0);
            k_target   = ($urandom_range(0, 1023) << 2) |
                         (($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0);
            tick();
        end
        k_flush = 1'b0;
        run(10);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
